// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter and its grant session controller.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE,
    FLUSH
  } state_t;

  // Index of the set bit in a one-hot vector (bitwise OR of set indices if not one-hot).
  function automatic logic [31:0] onehot2idx(input logic [31:0] vec);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) result = result | 32'(i);
    end
    return result;
  endfunction

endpackage

// File: rtl/onehot_check.sv
// Combinational classifier for a grant vector: empty, one-hot, and the one-hot index.
module onehot_check
  import arb_pkg::*;
#(
  parameter int N = N_REQ,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic          is_zero,
  output logic          is_onehot,
  output logic [PW-1:0] idx
);

  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  always_comb begin
    is_zero   = (vec == '0);
    is_onehot = !is_zero && ((vec & (vec - N'(1))) == '0);
    idx       = PW'(onehot2idx(32'(vec)));
  end

endmodule

// File: rtl/grant_session_ctrl.sv
// Locks an arbiter grant into a bus session, tracks it to completion or timeout,
// advances the round-robin pointer, then ignores stale grants still in the arbiter pipeline.
module grant_session_ctrl
  import arb_pkg::*;
#(
  parameter int N         = N_REQ,
  parameter int MAX_HOLD  = 16,
  parameter int FLUSH_CYC = 3,
  localparam int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  grant,
  input  logic [N-1:0]  done,
  output logic [PW-1:0] ptr,
  output logic [PW-1:0] owner,
  output logic          owner_valid,
  output logic [N-1:0]  ack,
  output logic          timeout,
  output logic          grant_err
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int FW = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX   = HW'(MAX_HOLD);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYC);
  localparam logic [N-1:0]  ONE_N      = N'(1);

  state_t         state;
  logic [HW-1:0]  hold_cnt;
  logic [FW-1:0]  flush_cnt;
  logic           g_zero;
  logic           g_onehot;
  logic [PW-1:0]  g_idx;
  logic [PW-1:0]  next_ptr;

  onehot_check #(.N(N)) u_grant_chk (
    .vec       (grant),
    .is_zero   (g_zero),
    .is_onehot (g_onehot),
    .idx       (g_idx)
  );

  // Pointer moves one past the finished owner so it gets lowest priority next round.
  always_comb begin
    next_ptr = (owner == PW'(N - 1)) ? '0 : owner + PW'(1);
  end

  // Session FSM with hold and flush counters; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      ack         <= '0;
      timeout     <= 1'b0;
      grant_err   <= 1'b0;
      hold_cnt    <= '0;
      flush_cnt   <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (!g_zero && !g_onehot) begin
            grant_err <= 1'b1;
          end else if (g_onehot && req[g_idx]) begin
            owner       <= g_idx;
            owner_valid <= 1'b1;
            ack         <= ONE_N << g_idx;
            hold_cnt    <= HW'(1);
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (done[owner] || !req[owner]) begin
            owner_valid <= 1'b0;
            ack         <= '0;
            state       <= RELEASE;
          end else if (hold_cnt == HOLD_MAX) begin
            owner_valid <= 1'b0;
            ack         <= '0;
            timeout     <= 1'b1;
            state       <= RELEASE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        RELEASE: begin
          ptr <= next_ptr;
          if (FLUSH_CYC == 0) begin
            state <= IDLE;
          end else begin
            flush_cnt <= FLUSH_INIT;
            state     <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_cnt != '0) flush_cnt <= flush_cnt - FW'(1);
          if (flush_cnt <= FW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grant_session_ctrl.sv
// Directed bench for grant_session_ctrl: sessions, pointer wrap, timeout, stale and multi-hot grants, async reset.
module tb_grant_session_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] done;
  logic [1:0] ptr;
  logic [1:0] owner;
  logic       owner_valid;
  logic [3:0] ack;
  logic       timeout;
  logic       grant_err;

  int checkCount = 0;
  int errorCount = 0;

  grant_session_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .done        (done),
    .ptr         (ptr),
    .owner       (owner),
    .owner_valid (owner_valid),
    .ack         (ack),
    .timeout     (timeout),
    .grant_err   (grant_err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] g, input logic [3:0] d);
    req   = r;
    grant = g;
    done  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleTicks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Directed scenario with hand-computed expectations; inputs change 1 time unit after each edge.
  initial begin
    rst_n = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    #12;
    checkOutput("rst_ptr", 32'(ptr), 32'd0);
    checkOutput("rst_owner", 32'(owner), 32'd0);
    checkOutput("rst_valid", 32'(owner_valid), 32'd0);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    checkOutput("rst_grant_err", 32'(grant_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Owner 2 session, done ends it, pointer goes to 3
    applyStimulus(4'b0100, 4'b0100, 4'b0000);
    tick();
    checkOutput("t1_ack", 32'(ack), 32'b0100);
    checkOutput("t1_owner", 32'(owner), 32'd2);
    checkOutput("t1_valid", 32'(owner_valid), 32'd1);
    applyStimulus(4'b0100, 4'b0000, 4'b0100);
    tick();
    checkOutput("t1_ack_drop", 32'(ack), 32'd0);
    checkOutput("t1_valid_drop", 32'(owner_valid), 32'd0);
    checkOutput("t1_owner_hold", 32'(owner), 32'd2);
    checkOutput("t1_ptr_not_yet", 32'(ptr), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("t1_ptr", 32'(ptr), 32'd3);
    idleTicks(3);

    // Owner 3, done wraps the pointer to 0; grant held through flush is ignored
    applyStimulus(4'b1000, 4'b1000, 4'b0000);
    tick();
    checkOutput("t2_ack3", 32'(ack), 32'b1000);
    checkOutput("t2_owner3", 32'(owner), 32'd3);
    applyStimulus(4'b1000, 4'b0000, 4'b1000);
    tick();
    checkOutput("t2_ack3_drop", 32'(ack), 32'd0);
    checkOutput("t2_no_timeout", 32'(timeout), 32'd0);
    applyStimulus(4'b0001, 4'b0001, 4'b0000);
    tick();
    checkOutput("t2_ptr_wrap", 32'(ptr), 32'd0);
    checkOutput("t3_release_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t3_flush_ignore", 32'(ack), 32'd0);
      checkOutput("t3_flush_valid", 32'(owner_valid), 32'd0);
    end
    tick();
    checkOutput("t3_first_ack", 32'(ack), 32'b0001);
    checkOutput("t3_first_owner", 32'(owner), 32'd0);
    checkOutput("t3_first_valid", 32'(owner_valid), 32'd1);

    // Foreign done ignored, then owner 0 abandons its request
    applyStimulus(4'b0001, 4'b0000, 4'b1000);
    tick();
    checkOutput("t5_foreign_done", 32'(ack), 32'b0001);
    checkOutput("t5_still_valid", 32'(owner_valid), 32'd1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("t5_abandon_ack", 32'(ack), 32'd0);
    checkOutput("t5_abandon_tmo", 32'(timeout), 32'd0);
    tick();
    checkOutput("t5_ptr", 32'(ptr), 32'd1);
    idleTicks(3);

    // Stale grant with no request: no session
    applyStimulus(4'b0000, 4'b0010, 4'b0000);
    tick();
    checkOutput("t3_stale_ack", 32'(ack), 32'd0);
    checkOutput("t3_stale_valid", 32'(owner_valid), 32'd0);
    tick();
    checkOutput("t3_stale_ack2", 32'(ack), 32'd0);

    // Owner 1 held past the limit is forced out after 16 cycles
    applyStimulus(4'b0010, 4'b0010, 4'b0000);
    tick();
    checkOutput("t2_ack1", 32'(ack), 32'b0010);
    checkOutput("t2_owner1", 32'(owner), 32'd1);
    applyStimulus(4'b0010, 4'b0000, 4'b0000);
    for (int k = 1; k <= 15; k++) begin
      tick();
      checkOutput("t2_hold_ack", 32'(ack), 32'b0010);
      checkOutput("t2_hold_tmo", 32'(timeout), 32'd0);
    end
    tick();
    checkOutput("t2_tmo_ack", 32'(ack), 32'd0);
    checkOutput("t2_tmo_valid", 32'(owner_valid), 32'd0);
    checkOutput("t2_tmo_pulse", 32'(timeout), 32'd1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("t2_tmo_pulse_end", 32'(timeout), 32'd0);
    checkOutput("t2_tmo_ptr", 32'(ptr), 32'd2);
    idleTicks(3);

    // Multi-hot grant flags a sticky error and starts nothing
    applyStimulus(4'b0110, 4'b0110, 4'b0000);
    tick();
    checkOutput("t4_err_set", 32'(grant_err), 32'd1);
    checkOutput("t4_err_ack", 32'(ack), 32'd0);
    checkOutput("t4_err_valid", 32'(owner_valid), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("t4_err_sticky", 32'(grant_err), 32'd1);
    applyStimulus(4'b0001, 4'b0001, 4'b0000);
    tick();
    checkOutput("t4_clean_ack", 32'(ack), 32'b0001);
    checkOutput("t4_clean_owner", 32'(owner), 32'd0);
    checkOutput("t4_err_kept", 32'(grant_err), 32'd1);

    // Done arriving on the same edge the hold limit is reached is a normal release
    applyStimulus(4'b0001, 4'b0000, 4'b0000);
    idleTicks(15);
    checkOutput("t6_pre_limit_ack", 32'(ack), 32'b0001);
    applyStimulus(4'b0001, 4'b0000, 4'b0001);
    tick();
    checkOutput("t6_sim_ack", 32'(ack), 32'd0);
    checkOutput("t6_sim_no_tmo", 32'(timeout), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("t6_sim_ptr", 32'(ptr), 32'd1);
    checkOutput("t6_sim_tmo2", 32'(timeout), 32'd0);
    idleTicks(3);

    // Owner 2 with ptr 1, then asynchronous reset mid-session
    applyStimulus(4'b0100, 4'b0100, 4'b0000);
    tick();
    checkOutput("t6_ack2", 32'(ack), 32'b0100);
    checkOutput("t6_ptr1", 32'(ptr), 32'd1);
    applyStimulus(4'b0100, 4'b0000, 4'b0000);
    idleTicks(2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_arst_ack", 32'(ack), 32'd0);
    checkOutput("t6_arst_valid", 32'(owner_valid), 32'd0);
    checkOutput("t6_arst_ptr", 32'(ptr), 32'd0);
    checkOutput("t6_arst_owner", 32'(owner), 32'd0);
    checkOutput("t6_arst_err", 32'(grant_err), 32'd0);
    checkOutput("t6_arst_tmo", 32'(timeout), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
